// File: rtl/ov5640_pkg.sv
// Shared types and widths for the OV5640 power-up and register-load sequencer.
package ov5640_pkg;

    localparam int TIMER_W = 24;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 8;
    localparam int ENTRY_W = ADDR_W + DATA_W;
    localparam int IDX_W   = 8;

    typedef enum logic [3:0] {
        S_PWDN   = 4'd0,
        S_RST    = 4'd1,
        S_SETTLE = 4'd2,
        S_FETCH  = 4'd3,
        S_REQ    = 4'd4,
        S_WAIT   = 4'd5,
        S_NEXT   = 4'd6,
        S_DONE   = 4'd7,
        S_ERR    = 4'd8
    } seq_state_t;

    function automatic logic [ADDR_W-1:0] entry_addr(input logic [ENTRY_W-1:0] entry);
        return entry[ENTRY_W-1:DATA_W];
    endfunction

    function automatic logic [DATA_W-1:0] entry_data(input logic [ENTRY_W-1:0] entry);
        return entry[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/ov5640_reg_rom.sv
// Sensor init table: {16-bit register address, 8-bit value}, one-cycle registered read.
module ov5640_reg_rom
    import ov5640_pkg::*;
(
    input  logic               clk_i,
    input  logic [IDX_W-1:0]   idx,
    output logic [ENTRY_W-1:0] entry
);

    logic [ENTRY_W-1:0] rom_val;

    // Leading entries are the OV5640 software-reset / PLL bring-up; the tail is filler.
    always_comb begin
        rom_val = {8'h50, idx, 8'h00};
        case (idx)
            8'd0:    rom_val = 24'h3103_11;
            8'd1:    rom_val = 24'h3008_82;
            8'd2:    rom_val = 24'h3008_42;
            8'd3:    rom_val = 24'h3103_03;
            8'd4:    rom_val = 24'h3017_FF;
            8'd5:    rom_val = 24'h3018_FF;
            8'd6:    rom_val = 24'h3034_1A;
            8'd7:    rom_val = 24'h3037_13;
            8'd8:    rom_val = 24'h3108_01;
            8'd9:    rom_val = 24'h3630_36;
            8'd10:   rom_val = 24'h3631_0E;
            8'd11:   rom_val = 24'h3632_E2;
            default: rom_val = {8'h50, idx, 8'h00};
        endcase
    end

    always_ff @(posedge clk_i) begin
        entry <= rom_val;
    end

endmodule

// File: rtl/ov5640_power_seq.sv
// OV5640 power-up sequencer: PWDN/RESET timing, then writes the init table over SCCB with retries.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_PWDN   | sensor powered down, held in reset
// S_RST    | power applied, sensor reset still asserted
// S_SETTLE | reset released, waiting before first register write
// S_FETCH  | table index presented to the ROM
// S_REQ    | ROM entry captured onto cfg_addr_o/cfg_data_o
// S_WAIT   | write request outstanding, waiting for ack
// S_NEXT   | entry accepted, advance or finish
// S_DONE   | all entries written (terminal)
// S_ERR    | entry failed after all retries (terminal)
module ov5640_power_seq
    import ov5640_pkg::*;
#(
    parameter logic [23:0] PWDN_CYCLES   = 24'd100000,
    parameter logic [23:0] RST_CYCLES    = 24'd200000,
    parameter logic [23:0] SETTLE_CYCLES = 24'd2000000,
    parameter logic [7:0]  REG_NUM       = 8'd250,
    parameter logic [1:0]  RETRY_MAX     = 2'd3
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic        cam_pwdn_o,
    output logic        cam_rst_n_o,
    output logic        cfg_req_o,
    output logic [15:0] cfg_addr_o,
    output logic [7:0]  cfg_data_o,
    input  logic        cfg_ack_i,
    input  logic        cfg_err_i,
    output logic [7:0]  cfg_idx_o,
    output logic        init_done_o,
    output logic        init_err_o
);

    seq_state_t         state;
    seq_state_t         state_next;
    logic [TIMER_W-1:0] timer;
    logic [1:0]         retry_cnt;
    logic [ENTRY_W-1:0] rom_entry;
    logic               timed_state;

    ov5640_reg_rom u_rom (
        .clk_i (clk_i),
        .idx   (cfg_idx_o),
        .entry (rom_entry)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= S_PWDN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_PWDN: begin
                if (timer == PWDN_CYCLES - 24'd1) state_next = S_RST;
            end
            S_RST: begin
                if (timer == RST_CYCLES - 24'd1) state_next = S_SETTLE;
            end
            S_SETTLE: begin
                if (timer == SETTLE_CYCLES - 24'd1) begin
                    state_next = (REG_NUM == 8'd0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: state_next = S_REQ;
            S_REQ:   state_next = S_WAIT;
            S_WAIT: begin
                if (cfg_ack_i) begin
                    if (!cfg_err_i)                state_next = S_NEXT;
                    else if (retry_cnt < RETRY_MAX) state_next = S_REQ;
                    else                            state_next = S_ERR;
                end
            end
            S_NEXT: begin
                state_next = (cfg_idx_o == REG_NUM - 8'd1) ? S_DONE : S_FETCH;
            end
            S_DONE:  state_next = S_DONE;
            S_ERR:   state_next = S_ERR;
            default: state_next = S_PWDN;
        endcase
    end

    assign timed_state = (state == S_PWDN) || (state == S_RST) || (state == S_SETTLE);

    // Outputs are registered from the next state so each pin changes on the same edge as the state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            timer       <= '0;
            retry_cnt   <= 2'd0;
            cam_pwdn_o  <= 1'b1;
            cam_rst_n_o <= 1'b0;
            cfg_req_o   <= 1'b0;
            cfg_addr_o  <= 16'h0000;
            cfg_data_o  <= 8'h00;
            cfg_idx_o   <= 8'h00;
            init_done_o <= 1'b0;
            init_err_o  <= 1'b0;
        end else begin
            if (state_next != state) begin
                timer <= '0;
            end else if (timed_state) begin
                timer <= timer + 24'd1;
            end

            cam_pwdn_o  <= (state_next == S_PWDN);
            cam_rst_n_o <= !((state_next == S_PWDN) || (state_next == S_RST));
            cfg_req_o   <= (state_next == S_WAIT);
            init_done_o <= (state_next == S_DONE);
            init_err_o  <= (state_next == S_ERR);

            if (state == S_REQ) begin
                cfg_addr_o <= entry_addr(rom_entry);
                cfg_data_o <= entry_data(rom_entry);
            end

            if ((state == S_WAIT) && cfg_ack_i) begin
                if (!cfg_err_i) begin
                    retry_cnt <= 2'd0;
                end else if (retry_cnt < RETRY_MAX) begin
                    retry_cnt <= retry_cnt + 2'd1;
                end
            end

            if ((state == S_NEXT) && (state_next == S_FETCH)) begin
                cfg_idx_o <= cfg_idx_o + 8'd1;
            end
        end
    end

endmodule
